imem_loader: RTL

Boot-time instruction memory writer for the single-cycle core. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and drives the instruction memory's write port starting at word 0. It holds the core in reset until the image is loaded. It sits between the external boot link and the instruction memory, and is the writer for the memory that the fetch unit reads combinationally.

---
 rtl/imem_loader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a little-endian byte stream (count, data words, optional checksum),
// writes 32-bit words to instruction memory from word 0 and keeps the core in
// reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte;
// the modulo-256 sum of every accepted byte must then be 0x00.
module imem_loader #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byteValid,
  input  logic [7:0]        byteData,
  output logic              byteReady,
  output logic              memWriteEnable,
  output logic [ADDR_W-1:0] memAddress,
  output logic [XLEN-1:0]   memWriteData,
  output logic              coreReset,
  output logic              loadDone,
  output logic              loadError
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;
  // After the last data word the checksum byte is still outstanding.
  localparam state_t ST_AFTER_DATA = ST_CHECK;
`else
  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;
  localparam state_t ST_AFTER_DATA = ST_FLUSH;
`endif

  // Count limit widened by one bit so a 16-bit count compares without overflow.
  localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

  // Modulo-256 running sum used by the checksum check.
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    sum8 = acc + b;
  endfunction

  // Byte is accepted only while a loading state advertises ready.
  function automatic logic is_loading(input state_t st);
    case (st)
      ST_LEN0, ST_LEN1, ST_DATA: is_loading = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK:                  is_loading = 1'b1;
`endif
      default:                   is_loading = 1'b0;
    endcase
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [15:0]       len_r;
  logic [ADDR_W:0]   word_idx_r;     // one extra bit: N == 2^ADDR_W must not alias
  logic [ADDR_W:0]   word_nxt_s;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       asm_r;          // bytes 0..2 of the word being assembled
  logic              ready_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [XLEN-1:0]   wdata_r;
  logic              core_rst_r;
  logic              done_r;
  logic              error_r;
  logic              accept_s;
  logic              word_strobe_s;
  logic              last_word_s;
  logic [15:0]       len_full_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_r;
  logic [7:0]        sum_nxt_s;
  assign sum_nxt_s = sum8(sum_r, byteData);
`endif

  assign accept_s    = byteValid && ready_r;
  assign len_full_s  = {byteData, len_r[7:0]};
  assign word_nxt_s  = word_idx_r + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word_s = (16'(word_nxt_s) == len_r);

  // Next-state decode and the word-complete event.
  always_comb begin
    state_nxt_s   = state_r;
    word_strobe_s = 1'b0;
    case (state_r)
      ST_LEN0: begin
        if (accept_s) state_nxt_s = ST_LEN1;
        else          state_nxt_s = ST_LEN0;
      end
      ST_LEN1: begin
        if (accept_s) begin
          if ({1'b0, len_full_s} > DEPTH_L) state_nxt_s = ST_ERROR;
          else if (len_full_s == 16'd0)     state_nxt_s = ST_AFTER_DATA;
          else                              state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (accept_s && (byte_cnt_r == 2'd3)) begin
          word_strobe_s = 1'b1;
          if (last_word_s) state_nxt_s = ST_AFTER_DATA;
          else             state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          if (sum_nxt_s == 8'h00) state_nxt_s = ST_FLUSH;
          else                    state_nxt_s = ST_ERROR;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
`endif
      ST_FLUSH: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = ST_DONE;
      ST_ERROR: state_nxt_s = ST_ERROR;
      default:  state_nxt_s = ST_ERROR;
    endcase
  end

  // State register and status outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_LEN0;
      ready_r    <= 1'b1;
      core_rst_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ready_r    <= is_loading(state_nxt_s);
      core_rst_r <= (state_nxt_s != ST_DONE);
      done_r     <= (state_nxt_s == ST_DONE);
      error_r    <= (state_nxt_s == ST_ERROR);
    end
  end

  // Count capture, byte assembly and word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r      <= 16'd0;
      asm_r      <= 24'd0;
      byte_cnt_r <= 2'd0;
      word_idx_r <= '0;
    end else begin
      if (accept_s && (state_r == ST_LEN0)) len_r[7:0]  <= byteData;
      if (accept_s && (state_r == ST_LEN1)) len_r[15:8] <= byteData;
      if (accept_s && (state_r == ST_DATA)) begin
        asm_r      <= {byteData, asm_r[23:8]};
        byte_cnt_r <= byte_cnt_r + 2'd1;
      end
      if (word_strobe_s) word_idx_r <= word_nxt_s;
    end
  end

  // Memory write port: one-cycle strobe after the 4th byte of each word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      we_r <= word_strobe_s;
      if (word_strobe_s) begin
        addr_r  <= word_idx_r[ADDR_W-1:0];
        wdata_r <= {byteData, asm_r};
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Checksum accumulator over every accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sum_r <= 8'h00;
    else if (accept_s) sum_r <= sum_nxt_s;
    else               sum_r <= sum_r;
  end
`endif

  assign byteReady      = ready_r;
  assign memWriteEnable = we_r;
  assign memAddress     = addr_r;
  assign memWriteData   = wdata_r;
  assign coreReset      = core_rst_r;
  assign loadDone       = done_r;
  assign loadError      = error_r;

endmodule
